// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK transmit/receive pair: FSM state type and
// the tone half-period helper used for divider and analyzer constants.
package fsk_pkg;

    typedef enum logic {
        IDLE,
        TRANSMIT
    } fsk_state_t;

    // Clock cycles per half period of a square wave at tone_hz.
    // A zero tone yields 0 so that parameter checks reject it cleanly.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned tone_hz);
        if (tone_hz == 0) begin
            return 0;
        end
        return clk_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave divider: toggles every half_count cycles; restart realigns the
// phase so the wave starts high with a fresh count.
module tone_divider (
    input  logic        clock,
    input  logic        clear,
    input  logic        restart,
    input  logic [31:0] half_count,
    output logic        tone
);

    logic [31:0] count;

    // Half-period counter with phase restart.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            tone  <= 1'b0;
            count <= '0;
        end else if (restart) begin
            tone  <= 1'b1;
            count <= '0;
        end else if (count >= half_count - 32'd1) begin
            tone  <= ~tone;
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fsk_tone_generator.sv
// FSK transmitter: accepts bytes over valid/ready, sends them LSB-first, each
// bit as BIT_CYCLES cycles of a square wave at FREQUENCY0 ('0') or
// FREQUENCY1 ('1'). Back-to-back bytes are sent with no idle gap.
module fsk_tone_generator
    import fsk_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned FREQUENCY0      = 5000,
    parameter int unsigned FREQUENCY1      = 10000,
    parameter int unsigned BIT_CYCLES      = 200000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       sample_data,
    output logic       busy
);

    localparam int unsigned HALF0 = half_period(CLOCK_FREQUENCY, FREQUENCY0);
    localparam int unsigned HALF1 = half_period(CLOCK_FREQUENCY, FREQUENCY1);
    localparam logic [31:0] LAST_CYCLE = 32'(BIT_CYCLES - 1);

    generate
        if (HALF0 < 1 || HALF1 < 1 || BIT_CYCLES < 2) begin : g_bad_params
            $error("fsk_tone_generator: tone half periods must be >= 1 and BIT_CYCLES >= 2");
        end
    endgenerate

    fsk_state_t  state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_index;
    logic [31:0] bit_cnt;
    logic        bit_last;
    logic        byte_last;
    logic        transfer;
    logic        restart;
    logic [31:0] half_count;
    logic        tone;

    assign bit_last   = (bit_cnt == LAST_CYCLE);
    assign byte_last  = bit_last && (bit_index == 3'd7);
    assign data_ready = enable && ((state == IDLE) || byte_last);
    assign transfer   = data_valid && data_ready;

    // The divider is held in restart while idle, so the transfer edge itself
    // performs the bit-0 phase reset; in TRANSMIT it restarts at every bit end.
    assign restart    = (state == IDLE) || bit_last;
    assign half_count = shift_reg[0] ? 32'(HALF1) : 32'(HALF0);

    tone_divider u_divider (
        .clock      (clock),
        .clear      (clear),
        .restart    (restart),
        .half_count (half_count),
        .tone       (tone)
    );

    // Tone is forced low outside a byte; both operands are registers.
    assign sample_data = tone && busy;

    // Transmit FSM: byte capture, bit/cycle counting and LSB-first shifting.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_index <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state     <= TRANSMIT;
                        shift_reg <= data_in;
                        bit_index <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                TRANSMIT: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_index == 3'd7) begin
                            bit_index <= '0;
                            if (transfer) begin
                                shift_reg <= data_in;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
